// File: rtl/pay_pkg.sv
// Shared types and constants for the payment scheduler: default amount width,
// transaction FSM states, comparator result record and round-robin helper.
package pay_pkg;

    localparam int unsigned PAY_AMT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EVAL  = 2'd2,
        RESP  = 2'd3
    } pay_state_t;

    typedef struct packed {
        logic                 excess;
        logic                 short;
        logic [PAY_AMT_W-1:0] adjust;
    } pay_result_t;

    // Successor of source g in an n-entry round robin.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/pay_compare.sv
// Registered bill/paid comparator: flags over/under payment and the absolute
// difference, loaded once per evaluation and held until the next load.
module pay_compare
    import pay_pkg::*;
#(
    parameter int unsigned AMT_W = PAY_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [AMT_W-1:0] bill,
    input  logic [AMT_W-1:0] paid,
    output logic             excess,
    output logic             short,
    output logic [AMT_W-1:0] adjust
);

    // Larger operand is always the minuend, so the difference never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            excess <= 1'b0;
            short  <= 1'b0;
            adjust <= '0;
        end else if (load) begin
            excess <= (paid > bill);
            short  <= (paid < bill);
            adjust <= (paid > bill) ? (paid - bill) : (bill - paid);
        end
    end

endmodule

// File: rtl/pay_rr_arbiter.sv
// Round-robin picker: first requester at or above ptr wins, otherwise the
// lowest-numbered requester; produces a one-hot grant and its encoded index.
module pay_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id
);

    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pool;
    logic               found;

    always_comb begin
        hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi[i] = (ID_W'(i) >= ptr);
        end
        upper = req & hi;
        pool  = (|upper) ? upper : req;

        grant = '0;
        id    = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !found && pool[i]) begin
                grant[i] = 1'b1;
                id       = ID_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/payment_scheduler.sv
// Round-robin scheduler sharing one registered bill/paid comparator among
// NUM_REQ payment sources. Optional counters enabled by PAY_STATS_EN.
module payment_scheduler
    import pay_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AMT_W   = PAY_AMT_W,
    parameter int unsigned ID_W    = 2
`ifdef PAY_STATS_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*AMT_W-1:0] req_bill,
    input  logic [NUM_REQ*AMT_W-1:0] req_paid,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_excess,
    output logic                     rsp_short,
    output logic [AMT_W-1:0]         rsp_adjust,
`ifdef PAY_STATS_EN
    input  logic                     stat_clr,
    output logic [CNT_W-1:0]         stat_total,
    output logic [CNT_W-1:0]         stat_excess,
    output logic [CNT_W-1:0]         stat_short,
`endif
    output logic                     busy
);

    pay_state_t         state;
    pay_state_t         state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               arb_en;
    logic [AMT_W-1:0]   sel_bill;
    logic [AMT_W-1:0]   sel_paid;
    logic [AMT_W-1:0]   bill_q;
    logic [AMT_W-1:0]   paid_q;
    logic               rsp_fire;
    logic               eval_load;
    logic               cmp_rst;

    assign arb_en    = (state == GRANT);
    assign eval_load = (state == EVAL);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign cmp_rst   = ~reset;

    pay_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (gnt),
        .id    (gnt_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; GRANT falls back to IDLE if every request vanished.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = GRANT;
            GRANT:   state_nxt = (|gnt) ? EVAL : IDLE;
            EVAL:    state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the accept strobe is live only during the GRANT cycle.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state == GRANT) begin
            req_ready = gnt;
        end
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

    // Select the granted source's operands from the packed request buses.
    always_comb begin
        sel_bill = '0;
        sel_paid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_bill = req_bill[i*AMT_W +: AMT_W];
                sel_paid = req_paid[i*AMT_W +: AMT_W];
            end
        end
    end

    // Operand latch, owner ID, rr pointer and response-valid flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr       <= '0;
            bill_q    <= '0;
            paid_q    <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (state == GRANT && (|gnt)) begin
                bill_q <= sel_bill;
                paid_q <= sel_paid;
                rsp_id <= gnt_id;
                ptr    <= ID_W'(rr_next(32'(gnt_id), NUM_REQ));
            end
            if (state == EVAL) begin
                rsp_valid <= 1'b1;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Comparator outputs are the response payload registers; they load in EVAL.
    pay_compare #(
        .AMT_W (AMT_W)
    ) u_cmp (
        .clk    (clk),
        .rst    (cmp_rst),
        .load   (eval_load),
        .bill   (bill_q),
        .paid   (paid_q),
        .excess (rsp_excess),
        .short  (rsp_short),
        .adjust (rsp_adjust)
    );

`ifdef PAY_STATS_EN
    // Saturating counters of delivered results; clear beats increment.
    always_ff @(posedge clk) begin
        if (!reset || stat_clr) begin
            stat_total  <= '0;
            stat_excess <= '0;
            stat_short  <= '0;
        end else if (rsp_fire) begin
            if (stat_total != '1) begin
                stat_total <= stat_total + CNT_W'(1);
            end
            if (rsp_excess && stat_excess != '1) begin
                stat_excess <= stat_excess + CNT_W'(1);
            end
            if (rsp_short && stat_short != '1) begin
                stat_short <= stat_short + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/payment_scheduler.md
Name: payment_scheduler

Overview:
Shares the registered bill/paid comparison datapath between NUM_REQ payment sources (counter kiosks, online gateway, auto-debit) using round-robin arbitration. Each transaction latches one source's bill and paid amounts, drives them into the comparator for one evaluation, captures the excess/short/adjustment result, and returns it on a valid/ready response channel tagged with the source ID. Sits between the payment front-ends and the billing ledger.

Parameters:
NUM_REQ, 4, number of requesting sources (2..8)
AMT_W, 16, width of bill, paid and adjustment amounts
ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ
CNT_W, 16, width of statistics counters (used only with PAY_STATS_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low; sampled on rising clk edge
req_valid  in  NUM_REQ  per-source request valid
req_ready  out  NUM_REQ  per-source accept; one-hot or zero
req_bill  in  NUM_REQ*AMT_W  packed bill amounts; source i at [i*AMT_W +: AMT_W]
req_paid  in  NUM_REQ*AMT_W  packed paid amounts; same packing
rsp_valid  out  1  result available
rsp_ready  in  1  ledger accepts result
rsp_id  out  ID_W  index of the source that owns the result
rsp_excess  out  1  paid > bill
rsp_short  out  1  paid < bill
rsp_adjust  out  AMT_W  |paid - bill|, 0 when equal
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_excess=0; rsp_short=0; rsp_adjust=0; busy=0; rr pointer=0. Reset wins over every other event, including mid-transaction; any in-flight transaction is discarded.
- FSM states: IDLE, GRANT, EVAL, RESP.
- IDLE: if any req_valid, go to GRANT; else stay.
- GRANT (1 cycle): round-robin pick starting at the rr pointer. Assert req_ready[g] combinationally for that cycle only. Latch req_bill[g], req_paid[g] and ID g. Set rr pointer to (g+1) mod NUM_REQ. Go to EVAL. If all req_valid have dropped, return to IDLE with no grant.
- EVAL (1 cycle): the latched operands feed the comparator. The comparator registers at the end of this cycle. Go to RESP.
- RESP: capture the comparator outputs into the rsp_* registers and assert rsp_valid. Hold all rsp_* stable while rsp_valid=1 && rsp_ready=0. On rsp_valid && rsp_ready, clear rsp_valid the next cycle and go to IDLE.
- Latency: grant to rsp_valid is 2 cycles. Minimum spacing between grants is 4 cycles (IDLE, GRANT, EVAL, RESP).
- Handshake: a source transfers on req_valid[i] && req_ready[i]. Its bill and paid must be stable in that cycle. Sources must hold req_valid until accepted.
- Comparator semantics: equal amounts give excess=0, short=0, adjust=0. Never both flags set. Subtraction is unsigned with no wrap, because the larger operand is always the minuend.
- Boundary values: bill=0, paid=0xFFFF gives excess=1, adjust=0xFFFF. bill=0xFFFF, paid=0 gives short=1, adjust=0xFFFF.
- A req_valid arriving in any state other than IDLE waits; it is never dropped.
- A req_valid on an index >= NUM_REQ is ignored (this applies when NUM_REQ is not a power of 2).

Optional Feature:
PAY_STATS_EN
- Defined: adds outputs stat_total, stat_excess and stat_short, each CNT_W wide.
  - Each counter increments on the response handshake (rsp_valid && rsp_ready) according to the result.
  - Counters saturate at all-ones and reset to 0.
  - Adds input stat_clr: a synchronous clear that takes priority over increment in the same cycle.
- Undefined: none of these ports or counters exist; behaviour is otherwise identical.

Decomposition:
- Package pay_pkg holds:
  - AMT_W default constant.
  - State enum: IDLE, GRANT, EVAL, RESP.
  - Result typedef: struct of excess, short, adjust.
- The comparison datapath is instantiated once, unchanged. Its reset is the inverted active-low reset.
- One natural sub-module: pay_rr_arbiter, parameterised by NUM_REQ. Inputs are the request vector, the pointer and an enable. Outputs are a one-hot grant and an encoded ID.

Test Plan:
- Single source 0, bill=1200, paid=1500 -> req_ready[0] pulses for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, excess=1, short=0, adjust=300.
- Sources 1 and 3 both valid, equal amounts 500/500 -> grants in order 1, then 3; each response gives excess=0, short=0, adjust=0; rr pointer wraps to 0.
- All 4 sources held valid for 16 transactions -> grant order 0,1,2,3 repeating; no source starved.
- rsp_ready held low 5 cycles with bill=0xFFFF, paid=0 -> rsp_* stable throughout (short=1, adjust=0xFFFF); no new grant until the handshake completes.
- reset driven low during EVAL -> next cycle all outputs at reset values and state IDLE; the pending source is regranted after reset release.
- With PAY_STATS_EN: 3 excess, 2 short and 1 exact transaction -> stat_total=6, stat_excess=3, stat_short=2; stat_clr asserted together with a handshake -> counters read 0.
